uart8_core: RTL and testbench

- 8N1 UART: one receiver, one transmitter, shared clock and baud generator; 8 data bits, no parity, 1 stop bit, LSB first.
- Sits between an async serial pin pair (rx/tx) and a byte-wide parallel interface.
- Receiver oversamples 16x and samples each bit at mid-bit.
- Per-direction enables and busy/done/error flags.

---
 rtl/uart8_core.sv | 386 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart8_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_core.sv
// ---------------------------------------------------------------------------
// uart8_core
//   8N1 UART (8 data bits, no parity, one stop bit, LSB first) with one
//   receiver and one transmitter sharing a single baud generator.
//
//   The receiver oversamples RX_OVERSAMPLE times per bit and decides each bit
//   at mid-bit. The transmitter emits one bit per TX tick. A TX tick is one
//   full bit time (RX_OVERSAMPLE receiver ticks).
//
//   Optional build macro:
//     UART8_RX_MAJORITY_EN : when defined, every receiver bit decision (start,
//                            data, stop) is the 2-of-3 majority of the samples
//                            at RX_OVERSAMPLE/2-1, /2 and /2+1. The decision
//                            is made at the last of these samples. When the
//                            macro is undefined, a single sample is taken at
//                            RX_OVERSAMPLE/2.
//
// Parameters:
//   CLOCK_RATE    : system clock in Hz
//   BAUD_RATE     : serial bit rate
//   RX_OVERSAMPLE : receiver samples per bit (power of two, >= 8)
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   rxEn       : receiver enable; low aborts any frame and disarms the receiver
//   rx         : serial input (idle high), synchronised internally
//   rxBusy     : high from the verified start bit until the stop-bit decision
//   rxDone     : one-clock pulse when a new byte has been loaded into out
//   rxErr      : framing error flag; cleared by the next good frame or by rxEn low
//   out        : last correctly received byte
//   txEn       : transmitter enable (checked only between frames)
//   txStart    : frame request. It is level-sampled on TX tick boundaries
//                while the transmitter is idle, so the requester holds it
//                until txBusy rises.
//   in         : byte to transmit; latched when the frame starts
//   txBusy     : high for the 10 bit times of a frame
//   txDone     : one-clock pulse when the stop bit completes
//   tx         : serial output (idle high)
// ---------------------------------------------------------------------------
module uart8_core #(
  parameter int CLOCK_RATE    = 12000000,
  parameter int BAUD_RATE     = 9600,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  // Rounded clocks per receiver tick (78 at the default settings).
  localparam int RX_DIV_RAW = (CLOCK_RATE + (BAUD_RATE * RX_OVERSAMPLE) / 2) /
                              (BAUD_RATE * RX_OVERSAMPLE);
  localparam int RX_DIV     = (RX_DIV_RAW < 1) ? 1 : RX_DIV_RAW;
  localparam int DIV_W      = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int OS_W       = $clog2(RX_OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(RX_DIV - 1);
  localparam logic [OS_W-1:0]  SAMPLE_LAST = OS_W'(RX_OVERSAMPLE - 1);

  // The start-bit decision point is counted in receiver ticks after the
  // falling edge, minus one, because sampleCnt starts at 0 on the first tick.
`ifdef UART8_RX_MAJORITY_EN
  localparam logic [OS_W-1:0]  START_DECIDE = OS_W'(RX_OVERSAMPLE / 2);
`else
  localparam logic [OS_W-1:0]  START_DECIDE = OS_W'(RX_OVERSAMPLE / 2 - 1);
`endif

  // -------------------------------------------------------------------------
  // Free-running baud generator
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] divCnt;
  logic [OS_W-1:0]  txSubCnt;
  logic             rxTick;
  logic             txTick;

  assign rxTick = (divCnt == DIV_LAST);
  assign txTick = rxTick && (txSubCnt == SAMPLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt   <= '0;
      txSubCnt <= '0;
    end else begin
      if (rxTick) begin
        divCnt   <= '0;
        txSubCnt <= txSubCnt + 1'b1;   // wraps: RX_OVERSAMPLE is a power of two
      end else begin
        divCnt   <= divCnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Input synchroniser and falling-edge detector
  // -------------------------------------------------------------------------
  logic [1:0] rxSync;
  logic       rxPrev;
  logic       rxIn;
  logic       rxFall;
  logic       rxBit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxSync <= 2'b11;
      rxPrev <= 1'b1;
    end else begin
      rxSync <= {rxSync[0], rx};
      rxPrev <= rxSync[1];
    end
  end

  assign rxIn   = rxSync[1];
  assign rxFall = rxPrev & ~rxIn;

`ifdef UART8_RX_MAJORITY_EN
  // The two previous tick samples, combined with the current one at the
  // decision tick, give the three-sample vote.
  logic [1:0] sampleHist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleHist <= 2'b11;
    end else if (rxTick) begin
      sampleHist <= {sampleHist[0], rxIn};
    end
  end

  assign rxBit = (sampleHist[1] & sampleHist[0]) |
                 (sampleHist[1] & rxIn) |
                 (sampleHist[0] & rxIn);
`else
  assign rxBit = rxIn;
`endif

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rxState_t;

  rxState_t        rxState,   rxStateNext;
  logic [OS_W-1:0] sampleCnt, sampleCntNext;
  logic [2:0]      rxBitCnt,  rxBitCntNext;
  logic [7:0]      rxShift,   rxShiftNext;
  logic [7:0]      outReg,    outNext;
  logic            rxDoneReg, rxDoneNext;
  logic            rxErrReg,  rxErrNext;
  logic            rxBusyReg, rxBusyNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState   <= RX_WAIT_HIGH;
      sampleCnt <= '0;
      rxBitCnt  <= '0;
      rxShift   <= '0;
      outReg    <= '0;
      rxDoneReg <= 1'b0;
      rxErrReg  <= 1'b0;
      rxBusyReg <= 1'b0;
    end else begin
      rxState   <= rxStateNext;
      sampleCnt <= sampleCntNext;
      rxBitCnt  <= rxBitCntNext;
      rxShift   <= rxShiftNext;
      outReg    <= outNext;
      rxDoneReg <= rxDoneNext;
      rxErrReg  <= rxErrNext;
      rxBusyReg <= rxBusyNext;
    end
  end

  always_comb begin
    rxStateNext   = rxState;
    sampleCntNext = sampleCnt;
    rxBitCntNext  = rxBitCnt;
    rxShiftNext   = rxShift;
    outNext       = outReg;
    rxDoneNext    = 1'b0;
    rxErrNext     = rxErrReg;
    rxBusyNext    = rxBusyReg;

    if (!rxEn) begin
      // Disabled: drop any frame and re-arm from WAIT_HIGH once enabled, so a
      // line that is already low at enable time is never taken as a start bit.
      rxStateNext   = RX_WAIT_HIGH;
      sampleCntNext = '0;
      rxBitCntNext  = '0;
      rxBusyNext    = 1'b0;
      rxErrNext     = 1'b0;
    end else begin
      unique case (rxState)
        RX_WAIT_HIGH: begin
          // The line has to stay high for RX_OVERSAMPLE consecutive ticks.
          if (!rxIn) begin
            sampleCntNext = '0;
          end else if (rxTick) begin
            if (sampleCnt == SAMPLE_LAST) begin
              sampleCntNext = '0;
              rxStateNext   = RX_IDLE;
            end else begin
              sampleCntNext = sampleCnt + 1'b1;
            end
          end
        end

        RX_IDLE: begin
          if (rxFall) begin
            sampleCntNext = '0;
            rxStateNext   = RX_START;
          end
        end

        RX_START: begin
          if (rxTick) begin
            if (sampleCnt == START_DECIDE) begin
              sampleCntNext = '0;
              if (!rxBit) begin
                rxBitCntNext = '0;
                rxBusyNext   = 1'b1;
                rxStateNext  = RX_DATA;
              end else begin
                rxStateNext  = RX_IDLE;   // glitch, not a start bit
              end
            end else begin
              sampleCntNext = sampleCnt + 1'b1;
            end
          end
        end

        RX_DATA: begin
          // Decisions are one full bit apart, so they stay at mid-bit.
          if (rxTick) begin
            if (sampleCnt == SAMPLE_LAST) begin
              sampleCntNext = '0;
              rxShiftNext   = {rxBit, rxShift[7:1]};
              if (rxBitCnt == 3'd7) begin
                rxStateNext  = RX_STOP;
              end else begin
                rxBitCntNext = rxBitCnt + 1'b1;
              end
            end else begin
              sampleCntNext = sampleCnt + 1'b1;
            end
          end
        end

        RX_STOP: begin
          if (rxTick) begin
            if (sampleCnt == SAMPLE_LAST) begin
              sampleCntNext = '0;
              rxBusyNext    = 1'b0;
              if (rxBit) begin
                outNext     = rxShift;
                rxDoneNext  = 1'b1;
                rxErrNext   = 1'b0;
                rxStateNext = RX_IDLE;   // next start edge may follow at once
              end else begin
                rxErrNext   = 1'b1;
                rxStateNext = RX_WAIT_HIGH;
              end
            end else begin
              sampleCntNext = sampleCnt + 1'b1;
            end
          end
        end

        default: begin
          rxStateNext = RX_WAIT_HIGH;
        end
      endcase
    end
  end

  assign rxBusy = rxBusyReg;
  assign rxDone = rxDoneReg;
  assign rxErr  = rxErrReg;
  assign out    = outReg;

  // -------------------------------------------------------------------------
  // Transmitter FSM: every transition happens on a TX tick, so each bit on
  // the line lasts exactly one bit time.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  txState_t   txState,   txStateNext;
  logic [7:0] txShift,   txShiftNext;
  logic [2:0] txBitCnt,  txBitCntNext;
  logic       txOutReg,  txOutNext;
  logic       txBusyReg, txBusyNext;
  logic       txDoneReg, txDoneNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState   <= TX_IDLE;
      txShift   <= '0;
      txBitCnt  <= '0;
      txOutReg  <= 1'b1;
      txBusyReg <= 1'b0;
      txDoneReg <= 1'b0;
    end else begin
      txState   <= txStateNext;
      txShift   <= txShiftNext;
      txBitCnt  <= txBitCntNext;
      txOutReg  <= txOutNext;
      txBusyReg <= txBusyNext;
      txDoneReg <= txDoneNext;
    end
  end

  always_comb begin
    txStateNext  = txState;
    txShiftNext  = txShift;
    txBitCntNext = txBitCnt;
    txOutNext    = txOutReg;
    txBusyNext   = txBusyReg;
    txDoneNext   = 1'b0;

    if (txTick) begin
      unique case (txState)
        TX_IDLE: begin
          // txEn is only consulted here, so a frame in flight always finishes.
          if (txEn && txStart) begin
            txShiftNext = in;
            txOutNext   = 1'b0;
            txBusyNext  = 1'b1;
            txStateNext = TX_START;
          end
        end

        TX_START: begin
          txOutNext    = txShift[0];
          txShiftNext  = {1'b0, txShift[7:1]};
          txBitCntNext = '0;
          txStateNext  = TX_DATA;
        end

        TX_DATA: begin
          if (txBitCnt == 3'd7) begin
            txOutNext   = 1'b1;
            txStateNext = TX_STOP;
          end else begin
            txOutNext    = txShift[0];
            txShiftNext  = {1'b0, txShift[7:1]};
            txBitCntNext = txBitCnt + 1'b1;
          end
        end

        TX_STOP: begin
          txBusyNext  = 1'b0;
          txDoneNext  = 1'b1;
          txStateNext = TX_IDLE;
        end

        default: begin
          txStateNext = TX_IDLE;
        end
      endcase
    end
  end

  assign txBusy = txBusyReg;
  assign txDone = txDoneReg;
  assign tx     = txOutReg;

endmodule

// File: tb/tb_uart8_core.sv
// ---------------------------------------------------------------------------
// tb_uart8_core
//   Directed bench for uart8_core at its default parameters (12 MHz clock,
//   9600 baud, 16x oversampling). Serial frames are driven at 1250 clocks
//   per bit, the true 9600-baud period at 12 MHz. The long-bit case uses
//   1288 clocks per bit, which is 3% long.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart8_core;

  localparam int BIT_CLKS      = 1250;
  localparam int SLOW_BIT_CLKS = 1288;
  localparam int TX_BIT_CLKS   = 1248;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rxEn    = 1'b0;
  logic       rxDrv   = 1'b0;
  logic       loopEn  = 1'b0;
  logic       txEn    = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] inByte  = 8'h00;

  wire        rxLine;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] out;
  logic       txBusy;
  logic       txDone;
  logic       tx;

  assign rxLine = loopEn ? tx : rxDrv;

  uart8_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxEn    (rxEn),
    .rx      (rxLine),
    .rxBusy  (rxBusy),
    .rxDone  (rxDone),
    .rxErr   (rxErr),
    .out     (out),
    .txEn    (txEn),
    .txStart (txStart),
    .in      (inByte),
    .txBusy  (txBusy),
    .txDone  (txDone),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Cycle counters: a one-clock pulse adds exactly 1 to its counter.
  int rxDoneCnt  = 0;
  int txDoneCnt  = 0;
  int txBusyClks = 0;

  always @(posedge clk) begin
    if (rxDone) rxDoneCnt  <= rxDoneCnt + 1;
    if (txDone) txDoneCnt  <= txDoneCnt + 1;
    if (txBusy) txBusyClks <= txBusyClks + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one 8N1 frame on rxDrv. It also samples rxBusy at 400 and 900
  // clocks into the start bit, which brackets the start-bit decision.
  task automatic sendFrame(input logic [7:0] data, input int bitClks, input logic stopVal,
                           output logic busyEarly, output logic busyLate);
    logic [7:0] d;
    d = data;
    rxDrv = 1'b0;
    tick(400);
    busyEarly = rxBusy;
    tick(500);
    busyLate = rxBusy;
    tick(bitClks - 900);
    for (int b = 0; b < 8; b++) begin
      rxDrv = d[b];
      tick(bitClks);
    end
    rxDrv = stopVal;
    tick(bitClks);
  endtask

  initial begin
    logic       busyEarly;
    logic       busyLate;
    logic [9:0] txExp;
    int         base;
    int         txDoneBase;
    int         txBusyBase;
    int         t;

    // ---- reset state ----
    tick(3);
    check("rstOut",    out,    32'h00);
    check("rstRxBusy", rxBusy, 32'h0);
    check("rstRxDone", rxDone, 32'h0);
    check("rstRxErr",  rxErr,  32'h0);
    check("rstTxBusy", txBusy, 32'h0);
    check("rstTxDone", txDone, 32'h0);
    check("rstTx",     tx,     32'h1);
    rst_n = 1'b1;
    tick(2);

    // ---- enable while line low: must be ignored; then arm and take 0x56 ----
    rxEn = 1'b1;
    tick(1000);
    check("armLowIgnored", rxBusy, 32'h0);
    rxDrv = 1'b1;
    tick(4320);
    base = rxDoneCnt;
    sendFrame(8'h56, BIT_CLKS, 1'b1, busyEarly, busyLate);
    check("f56BusyEarly", busyEarly, 32'h0);
    check("f56BusyLate",  busyLate,  32'h1);
    check("f56DonePulse", rxDoneCnt - base, 32'd1);
    check("f56Out",       out,   32'h56);
    check("f56Err",       rxErr, 32'h0);
    check("f56BusyEnd",   rxBusy, 32'h0);
    tick(BIT_CLKS / 2);

    // ---- 0xA5 with stop bit low: framing error ----
    base = rxDoneCnt;
    sendFrame(8'hA5, BIT_CLKS, 1'b0, busyEarly, busyLate);
    tick(625);
    check("ferrBusyLate", busyLate, 32'h1);
    check("ferrErr",      rxErr,    32'h1);
    check("ferrNoDone",   rxDoneCnt - base, 32'd0);
    check("ferrOutKept",  out,      32'h56);
    check("ferrBusyEnd",  rxBusy,   32'h0);
    // Half a bit high, then a start-like low: not armed yet, so ignored.
    rxDrv = 1'b1;
    tick(625);
    rxDrv = 1'b0;
    tick(900);
    check("fakeStartIgnored", rxBusy, 32'h0);
    tick(350);
    rxDrv = 1'b1;
    tick(1875);
    check("errHeld", rxErr, 32'h1);

    // ---- TX held off while txEn low ----
    inByte  = 8'h3C;
    txStart = 1'b1;
    tick(1500);
    check("txEnLowIdle", txBusy, 32'h0);
    check("txEnLowLine", tx,     32'h1);

    // ---- TX 0x3C, looped back into RX ----
    loopEn     = 1'b1;
    txEn       = 1'b1;
    base       = rxDoneCnt;
    txDoneBase = txDoneCnt;
    t = 0;
    while (!txBusy && t < 1300) begin
      tick(1);
      t++;
    end
    check("txStartSeen", txBusy, 32'h1);
    txBusyBase = txBusyClks;
    txStart = 1'b0;
    inByte  = 8'hC3;                  // must not affect the frame in flight
    txExp   = {1'b1, 8'h3C, 1'b0};    // stop, data, start (index 0 first)
    tick(TX_BIT_CLKS / 2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("txBit%0d", k),  tx,     txExp[k]);
      check($sformatf("txBusy%0d", k), txBusy, 32'h1);
      if (k < 9) tick(TX_BIT_CLKS);
    end
    t = 0;
    while (txBusy && t < 2000) begin
      tick(1);
      t++;
    end
    check("txBusyFell", txBusy, 32'h0);
    tick(2);
    check("txBusyClks",  txBusyClks - txBusyBase, 32'd12480);
    check("txDonePulse", txDoneCnt - txDoneBase,  32'd1);
    check("loopDone",    rxDoneCnt - base,        32'd1);
    check("loopOut",     out,   32'h3C);
    check("loopErrClr",  rxErr, 32'h0);
    rxDrv  = 1'b1;
    loopEn = 1'b0;
    tick(BIT_CLKS);

    // ---- 0x56 with bits 3% long ----
    base = rxDoneCnt;
    sendFrame(8'h56, SLOW_BIT_CLKS, 1'b1, busyEarly, busyLate);
    check("slowDone", rxDoneCnt - base, 32'd1);
    check("slowOut",  out,   32'h56);
    check("slowErr",  rxErr, 32'h0);
    tick(625);

    // ---- abort by dropping rxEn after two data bits ----
    base  = rxDoneCnt;
    rxDrv = 1'b0;
    tick(BIT_CLKS);
    rxDrv = 1'b1;
    tick(BIT_CLKS);
    rxDrv = 1'b1;
    tick(BIT_CLKS);
    check("abortBusyBefore", rxBusy, 32'h1);
    rxEn = 1'b0;
    tick(2);
    check("abortBusyAfter", rxBusy, 32'h0);
    rxDrv = 1'b0;
    tick(BIT_CLKS);
    rxDrv = 1'b1;
    tick(BIT_CLKS);
    check("abortNoDone",  rxDoneCnt - base, 32'd0);
    check("abortOutKept", out, 32'h56);
    rxEn = 1'b1;
    tick(100);
    check("reenableIdle", rxBusy, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
